// File: rtl/coverfloat_bin_counter.sv
// coverfloat_bin_counter
//   Multi-channel coverage accumulator for floating-point test records.
//   NUM_CH record streams (op, rounding mode, format, flags) are arbitrated
//   round-robin into a record FIFO. The FIFO drains one record per cycle
//   into saturating op x rm bins, per-flag counters, a drop counter and
//   sticky flags. A snapshot request blocks the inputs and drains the FIFO,
//   then pulses snap_done. Counters are read back through a registered port.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   in_valid/ready per-channel handshake; in_op [32c+:32], in_rm/in_fmt/in_flags [8c+:8]
//   fmt_filter     count only records with this format (8'hFF counts every format)
//   clear          zero all counters and sticky flags
//   snap_req       block inputs, drain FIFO, then pulse snap_done
//   snap_done      one-cycle pulse once the FIFO is empty and every record is counted
//   rd_en, rd_flag, rd_op_idx, rd_rm_idx  readout request (bin or flag counter)
//   rd_valid, rd_data  readout response, one cycle after rd_en
//   sticky_flags   OR of flags[4:0] over all counted records
//   drop_cnt       records discarded for unknown op or rm > 4
//   state_dbg      current snapshot FSM state
//
// Handshake: a record moves on channel c in any cycle where in_valid[c] and
// in_ready[c] are both high at the rising clock edge. in_ready[c] is raised
// only for the single granted channel (first valid channel at or after the
// round-robin pointer), only in RUN and only while the FIFO has room.

module coverfloat_bin_counter #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    in_valid,
  output logic [NUM_CH-1:0]    in_ready,
  input  logic [NUM_CH*32-1:0] in_op,
  input  logic [NUM_CH*8-1:0]  in_rm,
  input  logic [NUM_CH*8-1:0]  in_fmt,
  input  logic [NUM_CH*8-1:0]  in_flags,
  input  logic [7:0]           fmt_filter,
  input  logic                 clear,
  input  logic                 snap_req,
  output logic                 snap_done,
  input  logic                 rd_en,
  input  logic                 rd_flag,
  input  logic [3:0]           rd_op_idx,
  input  logic [2:0]           rd_rm_idx,
  output logic                 rd_valid,
  output logic [CNT_W-1:0]     rd_data,
  output logic [4:0]           sticky_flags,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [1:0]           state_dbg
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 56;
  localparam int NUM_OPS = 16;
  localparam int NUM_RM  = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [REC_W-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic [CNT_W-1:0]  bin_q  [NUM_OPS][NUM_RM];
  logic [CNT_W-1:0]  bin_d  [NUM_OPS][NUM_RM];
  logic [CNT_W-1:0]  flag_q [NUM_RM];
  logic [CNT_W-1:0]  flag_d [NUM_RM];
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [4:0]        sticky_q, sticky_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic [REC_W-1:0]  push_rec;
  logic              fifo_full;
  logic              push;
  logic              pop;

  logic [REC_W-1:0]  head_rec;
  logic [31:0]       head_op;
  logic [7:0]        head_rm;
  logic [7:0]        head_fmt;
  logic [7:0]        head_flags;
  logic [27:0]       head_major;
  logic              op_ok;
  logic              rm_ok;
  logic              fmt_ok;
  logic              do_count;
  logic              do_drop;
  logic [3:0]        bin_op;
  logic [2:0]        bin_rm;

  function automatic logic [CNT_W-1:0] sat_upd(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  // Round-robin grant: scan channels starting at the pointer, take the first valid one.
  always_comb begin : grant_comb
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    push_rec  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(cand);
        push_rec  = {in_op[cand*32 +: 32], in_rm[cand*8 +: 8],
                     in_fmt[cand*8 +: 8], in_flags[cand*8 +: 8]};
      end
    end
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    push      = gnt_found && !fifo_full && (state_q == ST_RUN);
    in_ready  = '0;
    if (push) in_ready[gnt_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
  end

  // FIFO pointers; the head is popped every cycle the FIFO holds a record.
  always_comb begin
    pop      = (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Classify the head record. A format mismatch hides the record entirely,
  // so it never reaches the drop counter either.
  always_comb begin
    head_rec   = fifo_mem_q[rd_ptr_q];
    head_op    = head_rec[55:24];
    head_rm    = head_rec[23:16];
    head_fmt   = head_rec[15:8];
    head_flags = head_rec[7:0];
    head_major = head_op[31:4];
    op_ok      = (head_major >= 28'd1) && (head_major <= 28'd16);
    rm_ok      = (head_rm <= 8'd4);
    fmt_ok     = (fmt_filter == 8'hFF) || (head_fmt == fmt_filter);
    do_count   = pop && fmt_ok && op_ok && rm_ok;
    do_drop    = pop && fmt_ok && !(op_ok && rm_ok);
    // Major op 16 wraps to 0 in four bits, so the subtraction lands on bin 15.
    bin_op     = head_major[3:0] - 4'd1;
    bin_rm     = head_rm[2:0];
  end

  // Counter next state. clear zeroes the base value, so a record popped in
  // the same cycle is counted on top of the cleared state.
  always_comb begin
    for (int o = 0; o < NUM_OPS; o++) begin
      for (int r = 0; r < NUM_RM; r++) begin
        bin_d[o][r] = sat_upd(clear ? '0 : bin_q[o][r],
                              do_count && (bin_op == 4'(o)) && (bin_rm == 3'(r)));
      end
    end
    for (int b = 0; b < NUM_RM; b++) begin
      flag_d[b]   = sat_upd(clear ? '0 : flag_q[b], do_count && head_flags[b]);
      sticky_d[b] = (clear ? 1'b0 : sticky_q[b]) | (do_count & head_flags[b]);
    end
    drop_d = sat_upd(clear ? '0 : drop_q, do_drop);
  end

  // Readout samples next-state values so a read sees this cycle's update.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      if (rd_rm_idx > 3'd4)  rd_data_d = '0;
      else if (rd_flag)      rd_data_d = flag_d[rd_rm_idx];
      else                   rd_data_d = bin_d[rd_op_idx][rd_rm_idx];
    end
  end

  // Snapshot FSM. An empty FIFO in DRAIN means the last record was already
  // popped and counted, so DONE follows immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (snap_req) state_d = ST_DRAIN;
      ST_DRAIN: if (count_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      sticky_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int o = 0; o < NUM_OPS; o++)
        for (int r = 0; r < NUM_RM; r++) bin_q[o][r] <= '0;
      for (int b = 0; b < NUM_RM; b++) flag_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      sticky_q   <= sticky_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int o = 0; o < NUM_OPS; o++)
        for (int r = 0; r < NUM_RM; r++) bin_q[o][r] <= bin_d[o][r];
      for (int b = 0; b < NUM_RM; b++) flag_q[b] <= flag_d[b];
    end
  end

  assign snap_done    = (state_q == ST_DONE);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign sticky_flags = sticky_q;
  assign drop_cnt     = drop_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_coverfloat_bin_counter.sv
// Testbench for coverfloat_bin_counter: a two-channel 16-bit instance driven
// with directed and random record streams and checked by a reference model
// plus a readout scoreboard, and a one-channel 4-bit instance for saturation
// and clear-with-pop behaviour.

module tb_coverfloat_bin_counter;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int MAXV   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [NUM_CH-1:0]    in_valid, in_ready;
  logic [NUM_CH*32-1:0] in_op;
  logic [NUM_CH*8-1:0]  in_rm, in_fmt, in_flags;
  logic [7:0]           fmt_filter;
  logic                 clear, snap_req, snap_done;
  logic                 rd_en, rd_flag, rd_valid;
  logic [3:0]           rd_op_idx;
  logic [2:0]           rd_rm_idx;
  logic [CNT_W-1:0]     rd_data, drop_cnt;
  logic [4:0]           sticky_flags;
  logic [1:0]           state_dbg;

  logic [31:0] ch_op    [NUM_CH];
  logic [7:0]  ch_rm    [NUM_CH];
  logic [7:0]  ch_fmt   [NUM_CH];
  logic [7:0]  ch_flags [NUM_CH];

  always_comb begin
    in_op = '0; in_rm = '0; in_fmt = '0; in_flags = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_op[c*32 +: 32]  = ch_op[c];
      in_rm[c*8 +: 8]    = ch_rm[c];
      in_fmt[c*8 +: 8]   = ch_fmt[c];
      in_flags[c*8 +: 8] = ch_flags[c];
    end
  end

  coverfloat_bin_counter #(.NUM_CH(NUM_CH), .FIFO_DEPTH(8), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rm(in_rm), .in_fmt(in_fmt), .in_flags(in_flags),
    .fmt_filter(fmt_filter), .clear(clear), .snap_req(snap_req), .snap_done(snap_done),
    .rd_en(rd_en), .rd_flag(rd_flag), .rd_op_idx(rd_op_idx), .rd_rm_idx(rd_rm_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .sticky_flags(sticky_flags),
    .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  // ---------------- small saturation DUT ----------------
  logic        s_in_valid, s_in_ready, s_clear, s_snap_done;
  logic [31:0] s_op;
  logic [7:0]  s_rm, s_fmt, s_flags;
  logic        s_rd_en, s_rd_flag, s_rd_valid;
  logic [3:0]  s_rd_op_idx;
  logic [2:0]  s_rd_rm_idx;
  logic [3:0]  s_rd_data, s_drop_cnt;
  logic [4:0]  s_sticky;
  logic [1:0]  s_state_dbg;

  coverfloat_bin_counter #(.NUM_CH(1), .FIFO_DEPTH(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_op(s_op), .in_rm(s_rm), .in_fmt(s_fmt), .in_flags(s_flags),
    .fmt_filter(8'hFF), .clear(s_clear), .snap_req(1'b0), .snap_done(s_snap_done),
    .rd_en(s_rd_en), .rd_flag(s_rd_flag), .rd_op_idx(s_rd_op_idx), .rd_rm_idx(s_rd_rm_idx),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .sticky_flags(s_sticky),
    .drop_cnt(s_drop_cnt), .state_dbg(s_state_dbg)
  );

  // ---------------- reference model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_bin [16][5];
  int         m_flag [5];
  int         m_drop;
  logic [4:0] m_sticky;
  logic [7:0] cur_filter;
  int         m_ptr;
  bit         blocked;
  bit         accepted [NUM_CH];
  int         xfer_cnt [NUM_CH];
  int         s_xfers;
  logic [CNT_W-1:0] exp_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  function automatic void model_zero();
    for (int o = 0; o < 16; o++) for (int r = 0; r < 5; r++) m_bin[o][r] = 0;
    for (int b = 0; b < 5; b++) m_flag[b] = 0;
    m_drop = 0;
    m_sticky = '0;
  endfunction

  // Coverage rule: format filter first, then op/rm validity, then bins and flags.
  function automatic void model_apply(input logic [31:0] op, input logic [7:0] rm,
                                      input logic [7:0] fmt, input logic [7:0] flags);
    int major;
    if (cur_filter != 8'hFF && fmt != cur_filter) return;
    major = int'(op >> 4);
    if (major >= 1 && major <= 16 && rm <= 8'd4) begin
      m_bin[major-1][rm] = sat_inc(m_bin[major-1][rm]);
      for (int b = 0; b < 5; b++)
        if (flags[b]) begin
          m_flag[b] = sat_inc(m_flag[b]);
          m_sticky[b] = 1'b1;
        end
    end else begin
      m_drop = sat_inc(m_drop);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [NUM_CH-1:0] exp_rdy;
    logic [CNT_W-1:0]  e;
    bit found;
    int c;
    if (reset) begin
      m_ptr = 0;
      blocked = 0;
      for (int k = 0; k < NUM_CH; k++) accepted[k] = 0;
    end else begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_valid_unexpected", rd_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e);
        end
      end
      exp_rdy = '0;
      found = 0;
      if (!blocked)
        for (int k = 0; k < NUM_CH; k++) begin
          c = (m_ptr + k) % NUM_CH;
          if (!found && in_valid[c]) begin
            exp_rdy[c] = 1'b1;
            found = 1;
          end
        end
      check("in_ready", in_ready, exp_rdy);
      if (!blocked) check("snap_done_in_run", snap_done, 1'b0);
      for (int k = 0; k < NUM_CH; k++) begin
        accepted[k] = in_valid[k] && in_ready[k];
        if (accepted[k]) begin
          model_apply(ch_op[k], ch_rm[k], ch_fmt[k], ch_flags[k]);
          m_ptr = (k + 1) % NUM_CH;
          xfer_cnt[k]++;
        end
      end
      if (!blocked && snap_req) blocked = 1;
      else if (blocked && snap_done) blocked = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && s_in_valid && s_in_ready) s_xfers++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    in_valid = '0;
  endtask

  task automatic drive(input int c, input logic [31:0] op, input logic [7:0] rm,
                       input logic [7:0] fmt, input logic [7:0] flags);
    in_valid[c] = 1'b1;
    ch_op[c] = op; ch_rm[c] = rm; ch_fmt[c] = fmt; ch_flags[c] = flags;
  endtask

  task automatic rand_rec(input int c);
    logic [27:0] maj;
    maj = 28'($urandom_range(0, 18));
    if ($urandom_range(0, 9) == 0) ch_op[c] = $urandom();
    else ch_op[c] = {maj, 4'($urandom_range(0, 15))};
    ch_rm[c]    = 8'($urandom_range(0, 6));
    ch_fmt[c]   = 8'($urandom_range(0, 3));
    ch_flags[c] = 8'($urandom_range(0, 255));
  endtask

  // Random traffic; a stalled record is held until accepted.
  task automatic stream(input int cycles, input int snap_at);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      snap_req = (i == snap_at);
      for (int c = 0; c < NUM_CH; c++) begin
        if (!(in_valid[c] && !accepted[c])) begin
          in_valid[c] = ($urandom_range(0, 3) != 0);
          if (in_valid[c]) rand_rec(c);
        end
      end
    end
    @(posedge clk); #1;
    snap_req = 1'b0;
    set_idle();
  endtask

  task automatic quiesce();
    int lat;
    bit seen;
    lat = 0;
    while (blocked && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (blocked) check("unblock_timeout", blocked, 1'b0);
    @(posedge clk); #1;
    set_idle();
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    lat = 1;
    seen = 0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      if (snap_done) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("snap_latency", lat, 2);
    @(posedge clk); #1;
  endtask

  task automatic issue_read(input logic flag, input logic [3:0] op, input logic [2:0] rm,
                            input int exp);
    @(posedge clk); #1;
    rd_en = 1'b1; rd_flag = flag; rd_op_idx = op; rd_rm_idx = rm;
    exp_q.push_back(CNT_W'(exp));
  endtask

  task automatic read_all();
    int wait_cnt;
    for (int o = 0; o < 16; o++)
      for (int r = 0; r < 5; r++) issue_read(1'b0, 4'(o), 3'(r), m_bin[o][r]);
    for (int b = 0; b < 5; b++) issue_read(1'b1, 4'd0, 3'(b), m_flag[b]);
    for (int r = 5; r < 8; r++) issue_read(1'b0, 4'($urandom_range(0, 15)), 3'(r), 0);
    issue_read(1'b1, 4'd0, 3'd5, 0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("rd_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("sticky_flags", sticky_flags, m_sticky);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic s_read(input logic flag, input logic [2:0] rm, input int exp, input string nm);
    @(posedge clk); #1;
    s_rd_en = 1'b1; s_rd_flag = flag; s_rd_op_idx = 4'd0; s_rd_rm_idx = rm;
    @(posedge clk); #1;
    s_rd_en = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, s_rd_valid, 1'b1);
    check(nm, s_rd_data, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int x0, x1;
    reset = 1'b1;
    in_valid = '0; fmt_filter = 8'hFF; cur_filter = 8'hFF;
    clear = 0; snap_req = 0; rd_en = 0; rd_flag = 0; rd_op_idx = 0; rd_rm_idx = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_op[c] = '0; ch_rm[c] = '0; ch_fmt[c] = '0; ch_flags[c] = '0; xfer_cnt[c] = 0;
    end
    s_in_valid = 0; s_op = '0; s_rm = '0; s_fmt = '0; s_flags = '0; s_clear = 0;
    s_rd_en = 0; s_rd_flag = 0; s_rd_op_idx = 0; s_rd_rm_idx = 0; s_xfers = 0;
    model_zero();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_drop", drop_cnt, 0);
    check("rst_sticky", sticky_flags, 5'b0);
    check("rst_snap_done", snap_done, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_in_ready", in_ready, 2'b00);

    // Saturation instance: 20 identical records into a 4-bit bin
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_op = 32'h10; s_rm = 8'd1; s_fmt = 8'd0; s_flags = 8'h02;
    repeat (20) @(posedge clk);
    #1 s_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    check("sat_xfers", s_xfers, 20);
    s_read(1'b0, 3'd1, (s_xfers > 15) ? 15 : s_xfers, "sat_bin");
    s_read(1'b1, 3'd1, (s_xfers > 15) ? 15 : s_xfers, "sat_flag");
    // Clear in the same cycle the next record is popped
    @(posedge clk); #1;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_clear = 1'b1;
    @(posedge clk); #1;
    s_clear = 1'b0;
    s_read(1'b0, 3'd1, 1, "clr_pop_bin");
    s_read(1'b1, 3'd1, 1, "clr_pop_flag");
    check("clr_pop_sticky", s_sticky, 5'b00010);
    check("clr_pop_drop", s_drop_cnt, 0);

    // Single OP_ADD record with flag 0
    @(posedge clk); #1;
    drive(0, 32'h10, 8'd0, 8'd0, 8'h01);
    @(posedge clk); #1;
    set_idle();
    quiesce();
    read_all();
    check("t1_sticky_const", sticky_flags, 5'b00001);

    // Both channels valid for 4 cycles: grants alternate
    x0 = xfer_cnt[0]; x1 = xfer_cnt[1];
    @(posedge clk); #1;
    drive(0, 32'h30, 8'd2, 8'd1, 8'h04);
    drive(1, 32'h40, 8'd2, 8'd2, 8'h10);
    repeat (4) @(posedge clk);
    #1 set_idle();
    quiesce();
    check("alt_ch0", xfer_cnt[0] - x0, 2);
    check("alt_ch1", xfer_cnt[1] - x1, 2);
    read_all();

    // Unknown op, bad rm, and an FMSUB variant
    @(posedge clk); #1; drive(0, 32'h110, 8'd0, 8'd0, 8'h00);
    @(posedge clk); #1; drive(0, 32'h10,  8'd5, 8'd0, 8'h08);
    @(posedge clk); #1; drive(0, 32'h51,  8'd3, 8'd0, 8'h00);
    @(posedge clk); #1; set_idle();
    quiesce();
    check("drop_two", drop_cnt, 2);
    read_all();

    // Random rounds with a mid-stream snapshot and varying format filter
    for (int rnd = 0; rnd < 4; rnd++) begin
      cur_filter = (rnd == 0 || $urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
      @(posedge clk); #1;
      fmt_filter = cur_filter;
      stream(150, $urandom_range(30, 100));
      quiesce();
      read_all();
      if (rnd == 2) begin
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        model_zero();
        read_all();
      end
    end

    // Reset while draining: record discarded, no snap_done
    cur_filter = 8'hFF;
    @(posedge clk); #1;
    fmt_filter = 8'hFF;
    drive(0, 32'h20, 8'd1, 8'd0, 8'h01);
    snap_req = 1'b1;
    @(posedge clk); #1;
    set_idle(); snap_req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_zero();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_drain_no_done", snap_done, 1'b0);
    end
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
